triangle_tracker: RTL
=====================

Name: triangle_tracker

Overview:
Consumer-side monitor for the sketch datapath's triangle-wave position sources. It samples an N-bit waveform on each enable, classifies every step, and tracks sweep direction. It detects peaks and troughs, measures the sweep period in steps, and flags any sample sequence that a legal triangle source cannot produce. It sits downstream of the axis generators and feeds status and debug logic.

Parameters:
N, 8, sample width in bits
PERIOD_W, 16, width of step counter and period output

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
ena  input  1  sample valid; sample is consumed only on clk edges where ena=1
sample  input  N  waveform value
dir  output  1  current sweep direction: 0=up, 1=down
peak  output  1  one-cycle pulse: up-to-down turn detected
trough  output  1  one-cycle pulse: down-to-up turn detected
period  output  PERIOD_W  steps between the last two peaks
period_valid  output  1  one-cycle pulse when period is updated
locked  output  1  last two measured periods are equal
error  output  1  sticky illegal-step flag; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, prev=0, step_cnt=0, have_peak=0. All outputs are 0.
- All outputs are registered. Each output reflects the sample taken on the same edge and is visible one cycle after that sample.
- When ena=0, no state, counter or prev change occurs, and all pulse outputs are 0.
- Step class on ena=1: delta = (sample - prev) mod 2^N.
  - UP: delta=1 and prev != 2^N-1.
  - DN: delta=2^N-1 and prev != 0.
  - HOLD: delta=0.
  - BAD: anything else, including the wraps 2^N-1->0 and 0->2^N-1.
- prev <= sample on every ena=1 cycle, regardless of class.
- State machine:
  - IDLE: first sample goes to ACQ; no classification, no error.
  - ACQ: UP -> UPS (dir=0). DN -> DNS (dir=1). HOLD stays in ACQ. BAD sets error and stays in ACQ.
  - UPS: UP stays. HOLD stays with no count. DN -> DNS, dir<=1, peak pulse. BAD sets error -> ACQ.
  - DNS: DN stays. HOLD stays with no count. UP -> UPS, dir<=0, trough pulse. BAD sets error -> ACQ.
- step_cnt counts UP/DN steps in UPS/DNS and saturates at 2^PERIOD_W-1.
- On the peak step:
  - If have_peak=1: period <= step_cnt+1 (saturating), period_valid pulse, locked <= (new period == old period).
  - In all cases: have_peak <= 1, step_cnt <= 0.
- On BAD: step_cnt <= 0, have_peak <= 0, locked <= 0. period keeps its last value.
- peak and trough are never asserted in the same cycle. period_valid only ever coincides with peak.
- dir holds its value through HOLD and through ACQ.
- Reset mid-sweep returns everything to IDLE immediately, regardless of ena.

Optional Feature:
Macro TRIANGLE_TRACKER_STRICT_RANGE_EN.
- Defined: a peak is legal only when prev=2^N-1, and a trough only when prev=0. A turn at any other value is treated as BAD: error set, no peak/trough pulse, go to ACQ.
- Not defined: turns at any value are accepted as peaks/troughs.

Test Plan:
- N=4, reset then full sweeps 0..15..0..15..0 with ena=1 every cycle:
  - peak pulses one cycle after sample 14 follows 15.
  - First peak gives no period_valid. Second peak gives period=30 with period_valid.
  - Third peak sets locked=1. trough pulses after 1 follows 0. error stays 0.
- Same sweep with ena low on alternate cycles, plus repeated (HOLD) samples inserted mid-ramp: identical period=30, no error, no extra pulses.
- Jump 5->8 mid-ramp: error=1 one cycle later; locked=0; have_peak cleared, so the next peak gives no period_valid; error stays 1 until reset.
- Wrap 15->0 with N=4: error=1 and no peak pulse. Then 0->15: error stays set, with no additional effect.
- Reset asserted mid-ramp with ena=1: all outputs 0 asynchronously, before the next edge. After release, the first sample gives no error regardless of value.
- With TRIANGLE_TRACKER_STRICT_RANGE_EN: turn 10->11->10 sets error with no peak. Without the macro, the same stimulus gives a peak pulse and no error.

Source files
------------

// File: rtl/triangle_tracker.sv
// triangle_tracker: consumer-side monitor for triangle-wave position sources.
// It classifies each sample step, tracks sweep direction, reports peaks and troughs,
// measures the peak-to-peak period, and keeps a sticky flag for illegal steps.
// Optional feature macro: TRIANGLE_TRACKER_STRICT_RANGE_EN
//   When defined, a turn is accepted only at full scale: a peak needs prev = 2^N-1
//   and a trough needs prev = 0. Turns at any other value count as illegal steps.
module triangle_tracker #(
    parameter int N        = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [N-1:0]        sample,
    output logic                dir,
    output logic                peak,
    output logic                trough,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        UPS  = 2'd2,
        DNS  = 2'd3
    } state_t;

    localparam logic [N-1:0]        SAMPLE_MAX = '1;
    localparam logic [N-1:0]        SAMPLE_ONE = N'(1);
    localparam logic [PERIOD_W-1:0] CNT_MAX    = '1;

    state_t                state;
    state_t                state_next;

    logic [N-1:0]          prev;
    logic [N-1:0]          prev_next;
    logic [PERIOD_W-1:0]   step_cnt;
    logic [PERIOD_W-1:0]   cnt_next;
    logic [PERIOD_W-1:0]   cnt_inc;
    logic                  have_peak;
    logic                  have_peak_next;

    logic                  dir_next;
    logic                  peak_next;
    logic                  trough_next;
    logic [PERIOD_W-1:0]   period_next;
    logic                  period_valid_next;
    logic                  locked_next;
    logic                  error_next;

    logic [N-1:0]          delta;
    logic                  step_up;
    logic                  step_dn;
    logic                  step_hold;
    logic                  step_bad;
    logic                  peak_ok;
    logic                  trough_ok;
    logic                  bad_hit;

    // Classify the incoming step against the previous sample (modular difference).
    always_comb begin
        delta     = sample - prev;
        step_up   = (delta == SAMPLE_ONE) && (prev != SAMPLE_MAX);
        step_dn   = (delta == SAMPLE_MAX) && (prev != '0);
        step_hold = (delta == '0);
        step_bad  = !(step_up || step_dn || step_hold);
    end

`ifdef TRIANGLE_TRACKER_STRICT_RANGE_EN
    // Turns are only legal at the extremes of the sample range.
    always_comb begin
        peak_ok   = (prev == SAMPLE_MAX);
        trough_ok = (prev == '0);
    end
`else
    // Turns are accepted at any sample value.
    always_comb begin
        peak_ok   = 1'b1;
        trough_ok = 1'b1;
    end
`endif

    // Saturating increment of the step counter; also serves as the new period value.
    always_comb begin
        if (step_cnt == CNT_MAX) begin
            cnt_inc = CNT_MAX;
        end else begin
            cnt_inc = step_cnt + PERIOD_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; nothing moves unless a sample is consumed.
    always_comb begin
        state_next        = state;
        prev_next         = prev;
        cnt_next          = step_cnt;
        have_peak_next    = have_peak;
        dir_next          = dir;
        peak_next         = 1'b0;
        trough_next       = 1'b0;
        period_next       = period;
        period_valid_next = 1'b0;
        locked_next       = locked;
        error_next        = error;
        bad_hit           = 1'b0;

        if (ena) begin
            prev_next = sample;
            case (state)
                IDLE: begin
                    state_next = ACQ;
                end
                ACQ: begin
                    if (step_up) begin
                        state_next = UPS;
                        dir_next   = 1'b0;
                    end else if (step_dn) begin
                        state_next = DNS;
                        dir_next   = 1'b1;
                    end else if (step_bad) begin
                        bad_hit = 1'b1;
                    end
                end
                UPS: begin
                    if (step_up) begin
                        cnt_next = cnt_inc;
                    end else if (step_dn && peak_ok) begin
                        state_next     = DNS;
                        dir_next       = 1'b1;
                        peak_next      = 1'b1;
                        have_peak_next = 1'b1;
                        cnt_next       = '0;
                        if (have_peak) begin
                            period_next       = cnt_inc;
                            period_valid_next = 1'b1;
                            locked_next       = (cnt_inc == period);
                        end
                    end else if (!step_hold) begin
                        bad_hit = 1'b1;
                    end
                end
                DNS: begin
                    if (step_dn) begin
                        cnt_next = cnt_inc;
                    end else if (step_up && trough_ok) begin
                        state_next  = UPS;
                        dir_next    = 1'b0;
                        trough_next = 1'b1;
                        cnt_next    = cnt_inc;
                    end else if (!step_hold) begin
                        bad_hit = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (bad_hit) begin
                state_next     = ACQ;
                error_next     = 1'b1;
                cnt_next       = '0;
                have_peak_next = 1'b0;
                locked_next    = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev         <= '0;
            step_cnt     <= '0;
            have_peak    <= 1'b0;
            dir          <= 1'b0;
            peak         <= 1'b0;
            trough       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            error        <= 1'b0;
        end else begin
            prev         <= prev_next;
            step_cnt     <= cnt_next;
            have_peak    <= have_peak_next;
            dir          <= dir_next;
            peak         <= peak_next;
            trough       <= trough_next;
            period       <= period_next;
            period_valid <= period_valid_next;
            locked       <= locked_next;
            error        <= error_next;
        end
    end

endmodule
